// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Control and buffering wrapper around a UART receive datapath.
//               - Free-running baud tick generator (divisor in clocks).
//               - Glitch-free reconfiguration: divisor and parity select are
//                 staged in shadow registers and applied only between frames.
//               - First-word fall-through receive FIFO with drop-on-full.
//               - Sticky overrun flag and saturating errored-frame counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH         receive FIFO entries (power of two, 2..16)
//   DIV_RST       baud divisor loaded at reset
// Ports
//   clk           single clock, all logic on the rising edge
//   reset         synchronous, active-high
//   cfg_we        config write strobe (captures cfg_div / cfg_p_sel)
//   cfg_div       baud divisor, clocks per baud_tick
//   cfg_p_sel     parity select for the RX datapath
//   baud_tick     one-cycle tick to the RX datapath
//   p_sel         applied parity select to the RX datapath
//   rx_busy       RX datapath is mid-frame
//   rx_done       one-cycle frame-complete pulse
//   rx_data       received byte, valid with rx_done
//   rx_p_error    parity error, valid with rx_done
//   rx_stop_error stop-bit error, valid with rx_done
//   m_valid       FIFO head valid
//   m_ready       consumer accepts the head entry
//   m_data        head byte (0 when empty)
//   m_err         head flags {stop_error, p_error} (0 when empty)
//   fifo_level    number of entries held
//   overrun       sticky: a frame was dropped because the FIFO was full
//   err_cnt       saturating count of errored frames
//   clr_status    clears overrun and err_cnt
// ============================================================================
module uart_rx_ctrl #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] DIV_RST = 16'd868
) (
  input  logic                     clk,
  input  logic                     reset,
  // configuration
  input  logic                     cfg_we,
  input  logic [15:0]              cfg_div,
  input  logic                     cfg_p_sel,
  // to / from the RX datapath
  output logic                     baud_tick,
  output logic                     p_sel,
  input  logic                     rx_busy,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  input  logic                     rx_p_error,
  input  logic                     rx_stop_error,
  // received-byte stream
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [7:0]               m_data,
  output logic [1:0]               m_err,
  // status
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overrun,
  output logic [7:0]               err_cnt,
  input  logic                     clr_status
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                c_PW       = $clog2(DEPTH);  // pointer width
  localparam int                c_LW       = c_PW + 1;       // level width
  localparam logic [c_LW-1:0]   c_DEPTH_LV = c_LW'(DEPTH);
  localparam logic [c_PW-1:0]   c_PTR_ONE  = c_PW'(1);
  localparam logic [c_LW-1:0]   c_LVL_ONE  = c_LW'(1);
  localparam logic [7:0]        c_ERR_MAX  = 8'hFF;

  // --------------------------------------------------------------------------
  // Reconfiguration FSM
  //   RUN   : normal operation
  //   PEND  : a config write is waiting for the datapath to go idle
  //   APPLY : one cycle in which the shadow config becomes live
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_apply;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    case (r_state)
      RUN: begin
        if (cfg_we) begin
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        // PEND always lasts at least one cycle, so an idle datapath at the
        // time of the write still passes through PEND exactly once.
        if (!rx_busy) begin
          w_state_nxt = APPLY;
        end
      end
      APPLY: begin
        w_apply     = 1'b1;
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shadow and live configuration
  // --------------------------------------------------------------------------
  logic [15:0] r_sh_div;
  logic        r_sh_p_sel;
  logic [15:0] r_div;
  logic        r_p_sel;
  logic [15:0] w_apply_div;
  logic        w_apply_p_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_div   <= DIV_RST;
      r_sh_p_sel <= 1'b0;
    end else if (cfg_we) begin
      r_sh_div   <= cfg_div;
      r_sh_p_sel <= cfg_p_sel;
    end
  end

  // A write landing in the APPLY cycle itself is forwarded straight to the
  // live registers, so the most recent write is never lost.
  assign w_apply_div   = cfg_we ? cfg_div   : r_sh_div;
  assign w_apply_p_sel = cfg_we ? cfg_p_sel : r_sh_p_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= DIV_RST;
      r_p_sel <= 1'b0;
    end else if (w_apply) begin
      r_div   <= w_apply_div;
      r_p_sel <= w_apply_p_sel;
    end
  end

  assign p_sel = r_p_sel;

  // --------------------------------------------------------------------------
  // Baud tick generator
  //   The counter runs 0..div-1; the tick is decoded from the count so that
  //   the first tick after a restart falls exactly div cycles later.
  //   Divisors of 0 and 1 both mean "tick every cycle".
  // --------------------------------------------------------------------------
  logic [15:0] r_cnt;
  logic        w_div_le1;
  logic        w_cnt_end;

  assign w_div_le1 = (r_div <= 16'd1);
  assign w_cnt_end = w_div_le1 || (r_cnt == (r_div - 16'd1));
  assign baud_tick = (r_state != APPLY) && w_cnt_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (w_apply || w_cnt_end) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  //   Entry layout: {stop_error, p_error, data[7:0]}
  // --------------------------------------------------------------------------
  logic [9:0]      r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [9:0]      w_head;

  assign w_full = (r_level == c_DEPTH_LV);
  assign w_pop  = m_valid & m_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign w_push = rx_done & (~w_full | w_pop);
  assign w_drop = rx_done & w_full & ~w_pop;

  // Storage carries no reset; validity is tracked by the level/pointers.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= {rx_stop_error, rx_p_error, rx_data};
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign m_valid    = (r_level != '0);
  assign w_head     = m_valid ? r_mem[r_rd_ptr] : 10'd0;
  assign m_data     = w_head[7:0];
  assign m_err      = w_head[9:8];
  assign fifo_level = r_level;

  // --------------------------------------------------------------------------
  // Status: sticky overrun and saturating errored-frame counter.
  //   clr_status takes effect first, then same-cycle events are counted, so
  //   no event is lost in the clearing cycle.
  // --------------------------------------------------------------------------
  logic       r_overrun;
  logic [7:0] r_err_cnt;
  logic       w_err_evt;

  // Errored frames are counted whether or not they fit in the FIFO.
  assign w_err_evt = rx_done & (rx_p_error | rx_stop_error);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (clr_status) begin
      r_overrun <= w_drop;
      r_err_cnt <= {7'd0, w_err_evt};
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_err_evt && (r_err_cnt != c_ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign overrun = r_overrun;
  assign err_cnt = r_err_cnt;

endmodule : uart_rx_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. A cycle-level reference
//               model (queue-based FIFO, arithmetic tick schedule, config
//               pending/apply bookkeeping) predicts every output each cycle;
//               directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int          DEPTH   = 4;
  localparam logic [15:0] DIV_RST = 16'd4;
  localparam int          LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [15:0]   cfg_div = 16'd0;
  logic          cfg_p_sel = 1'b0;
  logic          baud_tick;
  logic          p_sel;
  logic          rx_busy = 1'b0;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_p_error = 1'b0;
  logic          rx_stop_error = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [7:0]    m_data;
  logic [1:0]    m_err;
  logic [LW-1:0] fifo_level;
  logic          overrun;
  logic [7:0]    err_cnt;
  logic          clr_status = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH   (DEPTH),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_div       (cfg_div),
    .cfg_p_sel     (cfg_p_sel),
    .baud_tick     (baud_tick),
    .p_sel         (p_sel),
    .rx_busy       (rx_busy),
    .rx_done       (rx_done),
    .rx_data       (rx_data),
    .rx_p_error    (rx_p_error),
    .rx_stop_error (rx_stop_error),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_err         (m_err),
    .fifo_level    (fifo_level),
    .overrun       (overrun),
    .err_cnt       (err_cnt),
    .clr_status    (clr_status)
  );

  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model + scoreboard (evaluated mid-cycle on the falling edge)
  // --------------------------------------------------------------------------
  logic [9:0]  exp_q[$];
  logic [15:0] md_div, md_sh_div;
  logic        md_psel, md_sh_psel;
  int          md_base;          // first cycle of the current tick schedule
  bit          md_pend, md_apply, md_ovr, armed;
  int          md_err;
  logic        tick_exp, pop, full;
  logic [9:0]  head_exp;

  always @(negedge clk) begin
    if (armed) begin
      if (md_apply)            tick_exp = 1'b0;
      else if (md_div <= 16'd1) tick_exp = 1'b1;
      else tick_exp = (((cyc - md_base) % int'(md_div)) == (int'(md_div) - 1));
      head_exp = (exp_q.size() != 0) ? exp_q[0] : 10'd0;
      chk("baud_tick",  32'(baud_tick),  32'(tick_exp));
      chk("p_sel",      32'(p_sel),      32'(md_psel));
      chk("m_valid",    32'(m_valid),    32'(exp_q.size() != 0));
      chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      chk("head",       32'({m_err, m_data}), 32'(head_exp));
      chk("overrun",    32'(overrun),    32'(md_ovr));
      chk("err_cnt",    32'(err_cnt),    32'(md_err));
    end
    if (reset) begin
      exp_q.delete();
      md_div = DIV_RST; md_sh_div = DIV_RST;
      md_psel = 1'b0;   md_sh_psel = 1'b0;
      md_base = cyc + 1;
      md_pend = 1'b0; md_apply = 1'b0; md_ovr = 1'b0; md_err = 0;
      armed = 1'b1;
    end else if (armed) begin
      pop  = (exp_q.size() != 0) && m_ready;
      full = (exp_q.size() == DEPTH);
      if (clr_status) begin
        md_err = 0;
        md_ovr = 1'b0;
      end
      if (pop) void'(exp_q.pop_front());
      if (rx_done) begin
        if (!full || pop) exp_q.push_back({rx_stop_error, rx_p_error, rx_data});
        else              md_ovr = 1'b1;
        if ((rx_p_error || rx_stop_error) && md_err < 255) md_err++;
      end
      if (cfg_we) begin
        md_sh_div  = cfg_div;
        md_sh_psel = cfg_p_sel;
      end
      if (md_apply) begin
        md_div   = md_sh_div;
        md_psel  = md_sh_psel;
        md_base  = cyc + 1;
        md_apply = 1'b0;
      end else if (md_pend) begin
        if (!rx_busy) begin
          md_pend  = 1'b0;
          md_apply = 1'b1;
        end
      end else if (cfg_we) begin
        md_pend = 1'b1;
      end
    end
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // --------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    reset      = 1'b0;
    cfg_we     = 1'b0;
    rx_done    = 1'b0;
    clr_status = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic pe, input logic se);
    rx_done       = 1'b1;
    rx_data       = d;
    rx_p_error    = pe;
    rx_stop_error = se;
  endtask

  int n;
  int busy_left;
  int ready_pct;

  initial begin
    // ---------------- reset, then div=4 idle: ticks on cycles 3,7,11
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) chk("reset_m_valid", 32'(m_valid), 32'd0);
      n += int'(baud_tick);
    end
    chk("ticks_in_12_div4", 32'(n), 32'd3);

    // ---------------- config held off while the datapath is busy
    next_cycle();
    rx_busy = 1'b1; cfg_we = 1'b1; cfg_div = 16'd8; cfg_p_sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("p_sel_held", 32'(p_sel), 32'd0);
      next_cycle();
    end
    rx_busy = 1'b0;
    repeat (30) next_cycle();
    chk("p_sel_applied", 32'(p_sel), 32'd1);

    // ---------------- overrun: five frames into a 4-deep FIFO
    m_ready = 1'b0;
    frame(8'h55, 1'b0, 1'b0); next_cycle();
    frame(8'hAA, 1'b0, 1'b0); next_cycle();
    frame(8'h01, 1'b0, 1'b0); next_cycle();
    frame(8'h02, 1'b0, 1'b0); next_cycle();
    frame(8'h03, 1'b0, 1'b0); next_cycle();
    @(negedge clk);
    chk("level_full", 32'(fifo_level), 32'd4);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("head_0x55", 32'(m_data), 32'h55);
    m_ready = 1'b1;
    repeat (5) next_cycle();
    m_ready = 1'b0;
    clr_status = 1'b1;
    next_cycle();

    // ---------------- push into a full FIFO with a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      frame(8'(8'h10 + i), 1'b0, 1'b0);
      next_cycle();
    end
    frame(8'h77, 1'b0, 1'b0);
    m_ready = 1'b1;
    next_cycle();
    m_ready = 1'b0;
    @(negedge clk);
    chk("level_stays_4", 32'(fifo_level), 32'd4);
    chk("overrun_stays_0", 32'(overrun), 32'd0);
    m_ready = 1'b1;
    repeat (6) next_cycle();

    // ---------------- error counter saturation and clear-then-count
    for (int i = 0; i < 256; i++) begin
      frame(8'(i), 1'b1, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    next_cycle();
    clr_status = 1'b1;
    frame(8'hE1, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("err_cnt_clr_count", 32'(err_cnt), 32'd1);
    chk("m_err_parity", 32'(m_err), 32'd1);
    repeat (3) next_cycle();

    // ---------------- reset with queued data and a pending config
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame(8'(8'hC0 + i), 1'b0, 1'b1);
      next_cycle();
    end
    rx_busy = 1'b1; cfg_we = 1'b1; cfg_div = 16'd6; cfg_p_sel = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1; cfg_we = 1'b1; cfg_div = 16'd9; m_ready = 1'b1;
    frame(8'h99, 1'b1, 1'b1);
    next_cycle();
    rx_busy = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_p_sel", 32'(p_sel), 32'd0);
    n = int'(baud_tick);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      n += int'(baud_tick);
    end
    chk("rst_div_ticks", 32'(n), 32'd3);

    // ---------------- randomized traffic against the model
    busy_left = 0;
    for (int blk = 0; blk < 16; blk++) begin
      ready_pct = (blk % 4 == 0) ? 10 : int'($urandom_range(30, 100));
      for (int i = 0; i < 200; i++) begin
        next_cycle();
        if ($urandom_range(0, 2) == 0) begin
          frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end
        m_ready = ($urandom_range(1, 100) <= ready_pct);
        if (busy_left > 0) begin
          rx_busy = 1'b1;
          busy_left--;
        end else begin
          rx_busy = 1'b0;
          if ($urandom_range(0, 7) == 0) busy_left = int'($urandom_range(1, 20));
        end
        if ($urandom_range(0, 59) == 0) begin
          cfg_we    = 1'b1;
          cfg_div   = 16'($urandom_range(0, 10));
          cfg_p_sel = 1'($urandom_range(0, 1));
        end
        clr_status = ($urandom_range(0, 99) == 0);
        reset      = ($urandom_range(0, 999) == 0);
      end
    end
    next_cycle();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_rx_ctrl
`default_nettype wire
